// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: multiplexed 7-segment scanner shared by two requesters.
// A prescaler steps a digit index; at each frame boundary a small arbiter
// picks the display owner and snapshots its segment patterns so a frame
// never mixes two sources or two versions of one source.
// Ports:
//   clock       system clock
//   rst         synchronous active-high reset
//   req[1:0]    display requests (0 = timer, 1 = message)
//   cells0/1    per-requester segment patterns, digit k in [8k+7:8k]
//   blank       force display dark; scanning/arbitration keep running
//   gnt[1:0]    registered one-hot/zero grant
//   sig[11:0]   registered {digit enable one-hot, segments}
//   frame_done  one-cycle pulse after each frame boundary
module seg_scan_arbiter #(
  parameter int unsigned NUMCELLS    = 4,
  parameter int unsigned SCAN_DIV    = 12000,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [8*NUMCELLS-1:0] cells0,
  input  logic [8*NUMCELLS-1:0] cells1,
  input  logic                  blank,
  output logic [1:0]            gnt,
  output logic [11:0]           sig,
  output logic                  frame_done
);

  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned D_W    = (NUMCELLS > 1) ? $clog2(NUMCELLS) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  logic [CNT_W-1:0]           r_cnt;
  logic [D_W-1:0]             r_d;
  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [HOLD_W-1:0]          r_hold;
  logic [HOLD_W-1:0]          w_hold_nxt;
  logic [HOLD_W-1:0]          w_f;
  logic                       r_ptr;
  logic                       w_ptr_nxt;
  logic [NUMCELLS-1:0][7:0]   r_shadow;
  logic [11:0]                r_sig;
  logic                       r_frame_done;
  logic                       w_tick;
  logic                       w_boundary;
  logic [3:0]                 w_digit_en;
  logic [7:0]                 w_cell;

  assign w_tick     = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_boundary = w_tick && (r_d == D_W'(NUMCELLS - 1));

  // Frames completed by the current owner, saturating at HOLD_FRAMES.
  assign w_f = (r_hold >= HOLD_W'(HOLD_FRAMES - 1)) ? HOLD_W'(HOLD_FRAMES)
                                                    : r_hold + HOLD_W'(1);

  // Slot prescaler and digit index.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_cnt <= '0;
      r_d   <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) begin
        r_d <= (r_d == D_W'(NUMCELLS - 1)) ? '0 : r_d + D_W'(1);
      end
    end
  end

  // Arbiter state, hold counter, last-granted pointer and frame shadow.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state  <= IDLE;
      r_hold   <= '0;
      r_ptr    <= 1'b1;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_boundary) begin
        r_shadow <= (w_state_nxt == OWN1) ? cells1 : cells0;
      end
    end
  end

  // Next-state: decisions are taken only on the frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_ptr_nxt   = r_ptr;
    if (w_boundary) begin
      case (r_state)
        IDLE: begin
          if (req == 2'b11)  w_state_nxt = r_ptr ? OWN0 : OWN1;
          else if (req[0])   w_state_nxt = OWN0;
          else if (req[1])   w_state_nxt = OWN1;
        end
        OWN0: begin
          if (req[1] && (!req[0] || w_f == HOLD_W'(HOLD_FRAMES))) w_state_nxt = OWN1;
          else if (!req[0])                                       w_state_nxt = IDLE;
        end
        OWN1: begin
          if (req[0] && (!req[1] || w_f == HOLD_W'(HOLD_FRAMES))) w_state_nxt = OWN0;
          else if (!req[1])                                       w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
      w_hold_nxt = (w_state_nxt != r_state) ? '0 : w_f;
      if (w_state_nxt == OWN0 && r_state != OWN0) w_ptr_nxt = 1'b0;
      if (w_state_nxt == OWN1 && r_state != OWN1) w_ptr_nxt = 1'b1;
    end
  end

  assign w_digit_en = 4'(1) << r_d;
  assign w_cell     = r_shadow[r_d];

  // Output stage; slot position 0 is a dark cycle to hide digit-switch ghosting.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sig        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (r_cnt == '0 || r_state == IDLE || blank) r_sig <= '0;
      else                                        r_sig <= {w_digit_en, w_cell};
    end
  end

  assign gnt        = r_state;
  assign sig        = r_sig;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Bench for seg_scan_arbiter with a frame-level reference model.
module tb_seg_scan_arbiter;

  localparam int NC    = 4;
  localparam int SD    = 4;
  localparam int HF    = 2;
  localparam int FRAME = NC * SD;

  logic            clock = 1'b0;
  logic            rst   = 1'b1;
  logic [1:0]      req   = 2'b00;
  logic [8*NC-1:0] cells0 = '0;
  logic [8*NC-1:0] cells1 = '0;
  logic            blank = 1'b0;
  logic [1:0]      gnt;
  logic [11:0]     sig;
  logic            frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles since reset, owner (-1 none), frames held.
  int          m_cyc   = 0;
  int          m_owner = -1;
  int          m_held  = 0;
  int          m_last  = 1;
  logic [7:0]  m_shadow [NC];
  logic [11:0] m_sig = '0;
  logic        m_fd  = 1'b0;

  always #5 clock = ~clock;

  seg_scan_arbiter #(.NUMCELLS(NC), .SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .clock      (clock),
    .rst        (rst),
    .req        (req),
    .cells0     (cells0),
    .cells1     (cells1),
    .blank      (blank),
    .gnt        (gnt),
    .sig        (sig),
    .frame_done (frame_done)
  );

  function automatic logic [1:0] exp_gnt();
    if (m_owner < 0) return 2'b00;
    return (m_owner == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_update();
    int pos, slot, frames, nxt;
    bit bnd, mine, theirs;
    logic [3:0] en;
    if (rst) begin
      m_cyc = 0; m_owner = -1; m_held = 0; m_last = 1;
      m_sig = '0; m_fd = 1'b0;
      for (int k = 0; k < NC; k++) m_shadow[k] = '0;
    end else begin
      pos  = m_cyc % SD;
      slot = (m_cyc / SD) % NC;
      bnd  = ((m_cyc % FRAME) == FRAME - 1);
      if (pos == 0 || m_owner < 0 || blank) m_sig = '0;
      else begin
        en    = 4'b0001 << slot;
        m_sig = {en, m_shadow[slot]};
      end
      m_fd = bnd;
      if (bnd) begin
        frames = (m_held + 1 > HF) ? HF : m_held + 1;
        nxt = m_owner;
        if (m_owner < 0) begin
          if (req == 2'b11) nxt = 1 - m_last;
          else if (req[0])  nxt = 0;
          else if (req[1])  nxt = 1;
        end else begin
          mine   = req[m_owner];
          theirs = req[1 - m_owner];
          if (theirs && (!mine || frames == HF)) nxt = 1 - m_owner;
          else if (!mine)                        nxt = -1;
        end
        m_held = (nxt == m_owner) ? frames : 0;
        if (nxt >= 0 && nxt != m_owner) m_last = nxt;
        m_owner = nxt;
        for (int k = 0; k < NC; k++)
          m_shadow[k] = (nxt == 1) ? cells1[8*k +: 8] : cells0[8*k +: 8];
      end
      m_cyc++;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 2'b11; cells0 = 32'hFFFF_FFFF; cells1 = 32'hFFFF_FFFF;
    do_reset();
    n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_checks++;
    if (sig !== 12'h000) begin n_fail++; $display("FAIL reset_sig: got %h expected 000", sig); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
  endtask

  task automatic test_single_owner();
    logic [11:0] exp_sig [16];
    exp_sig = '{12'h000, 12'h166, 12'h166, 12'h166, 12'h000, 12'h24F, 12'h24F, 12'h24F,
                12'h000, 12'h45B, 12'h45B, 12'h45B, 12'h000, 12'h806, 12'h806, 12'h806};
    req = 2'b01; cells0 = 32'h065B_4F66; cells1 = 32'h1234_5678;
    do_reset();
    for (int s = 1; s <= 32; s++) begin
      step();
      n_checks++;
      if (gnt !== exp_gnt() || sig !== m_sig || frame_done !== m_fd) begin
        n_fail++;
        $display("FAIL single_model s=%0d: got gnt=%b sig=%h fd=%b expected gnt=%b sig=%h fd=%b",
                 s, gnt, sig, frame_done, exp_gnt(), m_sig, m_fd);
      end
      if (s == 15) begin
        n_checks++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_pre_gnt: got %b expected 00", gnt); end
      end
      if (s == 16) begin
        n_checks++;
        if (gnt !== 2'b01 || frame_done !== 1'b1) begin
          n_fail++; $display("FAIL single_grant: got gnt=%b fd=%b expected gnt=01 fd=1", gnt, frame_done);
        end
      end
      if (s > 16) begin
        n_checks++;
        if (sig !== exp_sig[s-17]) begin
          n_fail++; $display("FAIL single_sig s=%0d: got %h expected %h", s, sig, exp_sig[s-17]);
        end
      end
    end
  endtask

  task automatic test_alternation();
    logic [1:0] exp_b [6];
    exp_b = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    req = 2'b11; cells0 = $urandom; cells1 = $urandom;
    do_reset();
    for (int s = 1; s <= 6 * FRAME; s++) begin
      step();
      n_checks++;
      if (gnt !== exp_gnt() || sig !== m_sig || frame_done !== m_fd) begin
        n_fail++;
        $display("FAIL alt_model s=%0d: got gnt=%b sig=%h fd=%b expected gnt=%b sig=%h fd=%b",
                 s, gnt, sig, frame_done, exp_gnt(), m_sig, m_fd);
      end
      if (s % FRAME == 0) begin
        n_checks++;
        if (gnt !== exp_b[s/FRAME-1]) begin
          n_fail++; $display("FAIL alt_boundary%0d: got %b expected %b", s/FRAME, gnt, exp_b[s/FRAME-1]);
        end
      end
    end
  endtask

  // Continues from the owner-0 state left by test_alternation.
  task automatic test_drop();
    int fd_count = 0;
    for (int s = 0; s < 6; s++) step();
    req = 2'b00;
    for (int s = 1; s <= 10; s++) begin
      step();
      n_checks++;
      if (s < 10 && gnt !== 2'b01) begin
        n_fail++; $display("FAIL drop_hold s=%0d: got %b expected 01", s, gnt);
      end else if (s == 10 && (gnt !== 2'b00 || frame_done !== 1'b1)) begin
        n_fail++; $display("FAIL drop_idle: got gnt=%b fd=%b expected gnt=00 fd=1", gnt, frame_done);
      end
    end
    for (int s = 1; s <= 2 * FRAME; s++) begin
      step();
      if (frame_done === 1'b1) fd_count++;
      n_checks++;
      if (sig !== 12'h000 || gnt !== 2'b00) begin
        n_fail++; $display("FAIL drop_dark s=%0d: got gnt=%b sig=%h expected gnt=00 sig=000", s, gnt, sig);
      end
    end
    n_checks++;
    if (fd_count != 2) begin n_fail++; $display("FAIL drop_fd_count: got %0d expected 2", fd_count); end
  endtask

  task automatic test_shadow();
    logic [31:0] a, b;
    logic [11:0] e;
    a = $urandom; b = ~a;
    req = 2'b01; cells0 = a;
    do_reset();
    for (int s = 0; s < FRAME + 5; s++) step();
    cells0 = b;
    for (int s = 1; s <= 11; s++) begin
      step();
      n_checks++;
      if (gnt !== exp_gnt() || sig !== m_sig || frame_done !== m_fd) begin
        n_fail++;
        $display("FAIL shadow_model s=%0d: got gnt=%b sig=%h expected gnt=%b sig=%h", s, gnt, sig, exp_gnt(), m_sig);
      end
      if (s == 2) begin
        e = {4'b0010, a[15:8]};
        n_checks++;
        if (sig !== e) begin n_fail++; $display("FAIL shadow_old: got %h expected %h", sig, e); end
      end
    end
    step();
    step();
    e = {4'b0001, b[7:0]};
    n_checks++;
    if (sig !== e) begin n_fail++; $display("FAIL shadow_new: got %h expected %h", sig, e); end
  endtask

  task automatic test_blank();
    logic [11:0] e;
    req = 2'b10; cells1 = $urandom;
    do_reset();
    for (int s = 0; s < FRAME + 3; s++) step();
    blank = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      step();
      n_checks++;
      if (sig !== 12'h000 || gnt !== 2'b10) begin
        n_fail++; $display("FAIL blank_dark s=%0d: got gnt=%b sig=%h expected gnt=10 sig=000", s, gnt, sig);
      end
    end
    blank = 1'b0;
    step();
    step();
    e = {4'b0100, cells1[23:16]};
    n_checks++;
    if (sig !== e || gnt !== 2'b10) begin
      n_fail++; $display("FAIL blank_resume: got gnt=%b sig=%h expected gnt=10 sig=%h", gnt, sig, e);
    end
  endtask

  task automatic test_reset_mid();
    req = 2'b10; cells1 = $urandom; cells0 = $urandom;
    do_reset();
    for (int s = 0; s < FRAME + 10; s++) step();
    n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL rmid_pre: got %b expected 10", gnt); end
    rst = 1'b1;
    step();
    n_checks++;
    if (gnt !== 2'b00 || sig !== 12'h000 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL rmid_reset: got gnt=%b sig=%h fd=%b expected 00/000/0", gnt, sig, frame_done);
    end
    rst = 1'b0; req = 2'b11;
    for (int s = 1; s <= FRAME; s++) begin
      step();
      n_checks++;
      if (s < FRAME && (gnt !== 2'b00 || frame_done !== 1'b0)) begin
        n_fail++; $display("FAIL rmid_wait s=%0d: got gnt=%b fd=%b expected 00/0", s, gnt, frame_done);
      end else if (s == FRAME && (gnt !== 2'b01 || frame_done !== 1'b1)) begin
        n_fail++; $display("FAIL rmid_grant: got gnt=%b fd=%b expected 01/1", gnt, frame_done);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int s = 1; s <= 1200; s++) begin
      r     = $urandom_range(0, 9);
      req   = (r < 5) ? 2'b11 : 2'(r % 4);
      blank = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) cells0 = $urandom;
      if ($urandom_range(0, 5) == 0) cells1 = $urandom;
      step();
      n_checks++;
      if (gnt !== exp_gnt() || sig !== m_sig || frame_done !== m_fd) begin
        n_fail++;
        $display("FAIL random_model s=%0d: got gnt=%b sig=%h fd=%b expected gnt=%b sig=%h fd=%b",
                 s, gnt, sig, frame_done, exp_gnt(), m_sig, m_fd);
      end
    end
    rst = 1'b0; blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_alternation();
    test_drop();
    test_shadow();
    test_blank();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 SHALL have parameter NUMCELLS, default 4: number of display digits scanned.
REQ-002 SHALL have parameter SCAN_DIV, default 12000: clock cycles per digit slot (1 ms at 12 MHz); minimum 2.
REQ-003 SHALL have parameter HOLD_FRAMES, default 8: minimum frames an owner keeps the display while the other requester waits; minimum 1.
REQ-004 SHALL have port clock  input  1  system clock (12 MHz).
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  2  display requests; bit 0 is the timer source, bit 1 is the message source.
REQ-007 SHALL have port cells0  input  8*NUMCELLS  segment patterns from requester 0; digit k in bits [8k+7:8k].
REQ-008 SHALL have port cells1  input  8*NUMCELLS  segment patterns from requester 1, same layout.
REQ-009 SHALL have port blank  input  1  forces the display dark while high; scanning and arbitration continue.
REQ-010 SHALL have port gnt  output  2  one-hot or zero grant; the owner's bit is set.
REQ-011 SHALL have port sig  output  12  [7:0] segment pattern, [11:8] one-hot digit enable (sig[8] = digit 0); active-high.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse per completed scan frame.

Function
REQ-013 SHALL run prescaler cnt 0..SCAN_DIV-1, wrapping to 0; tick = (cnt == SCAN_DIV-1).
REQ-014 SHALL advance digit index d on tick, 0..NUMCELLS-1, wrapping to 0.
REQ-015 SHALL define frame boundary = tick && d == NUMCELLS-1; no other event changes gnt.
REQ-016 SHALL implement states IDLE (gnt=00), OWN0 (gnt=01), OWN1 (gnt=10); gnt is registered and equals the state.
REQ-017 At a boundary, SHALL compute f = min(hold+1, HOLD_FRAMES), the frames completed by the current owner.
REQ-018 IDLE at boundary: one requester -> grant it; both -> grant the one not granted last (pointer); none -> stay IDLE.
REQ-019 OWNx at boundary: other requests and (req[x]==0 or f==HOLD_FRAMES) -> switch to other; else req[x]==0 -> IDLE; else stay.
REQ-020 SHALL set hold to 0 on any grant change and to f when the grant is unchanged; hold is unused in IDLE.
REQ-021 SHALL update last-granted pointer whenever a new owner is granted.
REQ-022 SHALL capture a shadow copy of the new grantee's cells (cells0 or cells1, per next state) at every boundary; the shadow holds constant for the whole frame (no tearing).
REQ-023 SHALL register sig, one cycle latency: sig(t+1) = 0 if cnt(t)==0 (dead cycle against ghosting), state IDLE, or blank(t); else {onehot(d), shadow[8d+7:8d]}.
REQ-024 SHALL register frame_done: high for exactly the one cycle after each boundary, regardless of state or blank.
REQ-025 Requests dropped and reasserted within a frame SHALL have no effect; only req at the boundary cycle matters.

Reset
REQ-026 On rst high at a clock edge SHALL set cnt=0, d=0, state IDLE, gnt=00, hold=0, shadow=0, sig=0, frame_done=0, pointer=1 (requester 0 wins first tie).
REQ-027 Reset mid-frame SHALL discard the frame in progress; first boundary after release occurs SCAN_DIV*NUMCELLS cycles later.

Verification (SCAN_DIV=4, NUMCELLS=4, HOLD_FRAMES=2; frame = 16 cycles)
REQ-028 Reset, req=01, cells0=32'h06_5B_4F_66 -> gnt=01 after first boundary; sig cycles 000, 166, 000... per slot: 166,24F,45B,806, each held 3 cycles after 1 dead cycle.
REQ-029 req=11 from reset -> gnt=01 at boundary 1, stays for 2 frames, gnt=10 at boundary 3, back to 01 at boundary 5.
REQ-030 OWN0, req drops to 00 mid-frame -> gnt stays 01 to frame end, IDLE at boundary, sig=000 thereafter, frame_done still pulses every 16 cycles.
REQ-031 OWN0, cells0 changes mid-frame -> sig shows old patterns until boundary, new patterns from next frame.
REQ-032 blank=1 for 5 cycles while OWN1 -> sig=000 during the following 5 cycles, gnt unchanged; scan position unaffected.
REQ-033 rst asserted at cnt=2, d=2 in OWN1 -> next cycle gnt=00, sig=000; req=11 -> requester 0 granted 16 cycles after release.
